// File: rtl/draw_defs.sv
// Shared constants for the line rasteriser: screen size, coordinate widths, colours, FSM encodings.
package draw_defs;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  localparam logic [XW:0] SCREEN_WIDTH  = 9'd160;
  localparam logic [YW:0] SCREEN_HEIGHT = 8'd120;

  localparam logic [CW-1:0] BLACK  = 3'b000;
  localparam logic [CW-1:0] BLUE   = 3'b001;
  localparam logic [CW-1:0] GREEN  = 3'b010;
  localparam logic [CW-1:0] RED    = 3'b100;
  localparam logic [CW-1:0] YELLOW = 3'b110;
  localparam logic [CW-1:0] WHITE  = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  // Pixels outside the visible area still take a DRAW cycle but must not be written.
  function automatic logic on_screen(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return ({1'b0, px} < SCREEN_WIDTH) && ({1'b0, py} < SCREEN_HEIGHT);
  endfunction

endpackage

// File: rtl/line_drawer_bresenham_step.sv
// One combinational Bresenham iteration: both error updates use the incoming err.
module bresenham_step
  import draw_defs::*;
(
  input  logic signed [9:0]  i_err,
  input  logic signed [8:0]  i_dx,
  input  logic signed [8:0]  i_dy,
  input  logic               i_sx_neg,
  input  logic               i_sy_neg,
  input  logic [XW-1:0]      i_x,
  input  logic [YW-1:0]      i_y,
  output logic signed [9:0]  o_err,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y
);

  logic signed [10:0] w_e2;
  logic signed [10:0] w_dx_e;
  logic signed [10:0] w_dy_e;
  logic signed [9:0]  w_dx10;
  logic signed [9:0]  w_dy10;
  logic               w_step_x;
  logic               w_step_y;

  assign w_e2   = {i_err, 1'b0};
  assign w_dx_e = {{2{i_dx[8]}}, i_dx};
  assign w_dy_e = {{2{i_dy[8]}}, i_dy};
  assign w_dx10 = {i_dx[8], i_dx};
  assign w_dy10 = {i_dy[8], i_dy};

  assign w_step_x = (w_e2 >= w_dy_e);
  assign w_step_y = (w_e2 <= w_dx_e);

  assign o_err = i_err + (w_step_x ? w_dy10 : 10'sd0) + (w_step_y ? w_dx10 : 10'sd0);

  assign o_x = w_step_x ? (i_sx_neg ? i_x - X_ONE : i_x + X_ONE) : i_x;
  assign o_y = w_step_y ? (i_sy_neg ? i_y - Y_ONE : i_y + Y_ONE) : i_y;

endmodule

// File: rtl/line_drawer.sv
// Bresenham line rasteriser feeding the 160x120 VGA adapter pixel port, one pixel per clock.
module line_drawer
  import draw_defs::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y1,
  input  logic [CW-1:0] i_colour_in,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [CW-1:0] o_colour,
  output logic          o_plot,
  output logic          o_busy,
  output logic          o_done
);

  logic [1:0]        r_state;
  logic [XW-1:0]     r_x0;
  logic [YW-1:0]     r_y0;
  logic [XW-1:0]     r_x1;
  logic [YW-1:0]     r_y1;
  logic [CW-1:0]     r_col;
  logic signed [8:0] r_dx;
  logic signed [8:0] r_dy;
  logic              r_sx_neg;
  logic              r_sy_neg;
  logic signed [9:0] r_err;
  logic [XW-1:0]     r_cx;
  logic [YW-1:0]     r_cy;

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [CW-1:0]     r_colour;
  logic              r_plot;
  logic              r_busy;
  logic              r_done;

  logic [XW-1:0]     w_xdiff;
  logic [YW-1:0]     w_ydiff;
  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic signed [9:0] w_err0;
  logic signed [9:0] w_nerr;
  logic [XW-1:0]     w_nx;
  logic [YW-1:0]     w_ny;
  logic              w_at_end;

  // Setup values from the latched endpoints, consumed in INIT only.
  assign w_xdiff = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ydiff = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
  assign w_dx    = {1'b0, w_xdiff};
  assign w_dy    = -$signed({2'b00, w_ydiff});
  assign w_err0  = {w_dx[8], w_dx} + {w_dy[8], w_dy};

  assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);

  bresenham_step u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .i_x      (r_cx),
    .i_y      (r_cy),
    .o_err    (w_nerr),
    .o_x      (w_nx),
    .o_y      (w_ny)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_col    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x0    <= i_x0;
            r_y0    <= i_y0;
            r_x1    <= i_x1;
            r_y1    <= i_y1;
            r_col   <= i_colour_in;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_dx     <= w_dx;
          r_dy     <= w_dy;
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_err    <= w_err0;
          r_cx     <= r_x0;
          r_cy     <= r_y0;
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          r_x      <= r_cx;
          r_y      <= r_cy;
          r_colour <= r_col;
          r_plot   <= on_screen(r_cx, r_cy);
          // Reaching the endpoint is the only exit, so coordinates never wrap.
          if (w_at_end) begin
            r_state <= S_DONE;
          end else begin
            r_err <= w_nerr;
            r_cx  <= w_nx;
            r_cy  <= w_ny;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: pixel sequences, latency, clipping, reset and busy behaviour.
module tb_line_drawer;
  import draw_defs::*;

  logic          clk;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic [CW-1:0] colour_in;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  line_drawer dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_x0        (x0),
    .i_y0        (y0),
    .i_x1        (x1),
    .i_y1        (y1),
    .i_colour_in (colour_in),
    .o_x         (x),
    .o_y         (y),
    .o_colour    (colour),
    .o_plot      (plot),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then step through INIT: busy must rise, no plot yet.
  task automatic launch(input string tag, input int ax0, input int ay0,
                        input int ax1, input int ay1, input logic [CW-1:0] c);
    @(negedge clk);
    x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
    colour_in = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_after_accept"}, busy, 1);
    @(negedge clk);
    chk({tag, ".init_no_plot"}, plot, 0);
  endtask

  task automatic pix(input string tag, input int ex, input int ey,
                     input logic ep, input logic [CW-1:0] ec);
    @(negedge clk);
    chk({tag, ".plot"}, plot, ep);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    if (ep) chk({tag, ".colour"}, colour, ec);
  endtask

  task automatic fin(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_low"}, busy, 0);
    chk({tag, ".plot_low"}, plot, 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0;
    repeat (2) @(negedge clk);
    chk("rst.x", x, 0);
    chk("rst.y", y, 0);
    chk("rst.colour", colour, 0);
    chk("rst.plot", plot, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    reset = 1'b0;

    // start together with reset: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start.busy", busy, 0);

    // horizontal (0,0)->(5,0), GREEN
    launch("horiz", 0, 0, 5, 0, GREEN);
    for (int i = 0; i < 6; i++) pix($sformatf("horiz.p%0d", i), i, 0, 1'b1, GREEN);
    fin("horiz");

    // steep (0,0)->(2,5)
    launch("steep", 0, 0, 2, 5, WHITE);
    pix("steep.p0", 0, 0, 1'b1, WHITE);
    pix("steep.p1", 0, 1, 1'b1, WHITE);
    pix("steep.p2", 1, 2, 1'b1, WHITE);
    pix("steep.p3", 1, 3, 1'b1, WHITE);
    pix("steep.p4", 2, 4, 1'b1, WHITE);
    pix("steep.p5", 2, 5, 1'b1, WHITE);
    fin("steep");

    // reverse vertical (3,10)->(3,7)
    launch("rvert", 3, 10, 3, 7, RED);
    pix("rvert.p0", 3, 10, 1'b1, RED);
    pix("rvert.p1", 3, 9, 1'b1, RED);
    pix("rvert.p2", 3, 8, 1'b1, RED);
    pix("rvert.p3", 3, 7, 1'b1, RED);
    fin("rvert");

    // zero-length at bottom-right corner
    launch("zero", 159, 119, 159, 119, YELLOW);
    pix("zero.p0", 159, 119, 1'b1, YELLOW);
    fin("zero");

    // clipping (158,0)->(162,0)
    launch("clip", 158, 0, 162, 0, BLUE);
    pix("clip.p0", 158, 0, 1'b1, BLUE);
    pix("clip.p1", 159, 0, 1'b1, BLUE);
    pix("clip.p2", 160, 0, 1'b0, BLUE);
    pix("clip.p3", 161, 0, 1'b0, BLUE);
    pix("clip.p4", 162, 0, 1'b0, BLUE);
    fin("clip");

    // reset during the 3rd pixel of (0,0)->(20,20)
    launch("rmid", 0, 0, 20, 20, GREEN);
    pix("rmid.p0", 0, 0, 1'b1, GREEN);
    pix("rmid.p1", 1, 1, 1'b1, GREEN);
    pix("rmid.p2", 2, 2, 1'b1, GREEN);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid.plot", plot, 0);
    chk("rmid.busy", busy, 0);
    chk("rmid.done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rmid.idle_no_done", done, 0);
      chk("rmid.idle_no_plot", plot, 0);
    end

    // start while busy is ignored; changed endpoints are not used
    launch("ign", 0, 0, 3, 0, WHITE);
    start = 1'b1; x0 = 8'd50; y0 = 7'd50; x1 = 8'd60; y1 = 7'd60; colour_in = RED;
    pix("ign.p0", 0, 0, 1'b1, WHITE);
    pix("ign.p1", 1, 0, 1'b1, WHITE);
    start = 1'b0;
    pix("ign.p2", 2, 0, 1'b1, WHITE);
    pix("ign.p3", 3, 0, 1'b1, WHITE);
    fin("ign");
    chk("ign.stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
- Bresenham line rasteriser that sits directly upstream of the 160x120 VGA adapter.
- Accepts two endpoints and a colour on a start handshake, then emits one pixel per clock on x/y/colour/plot, wired straight to the adapter's pixel-write port.
- Replaces the full-screen fill loop as the pixel source whenever arbitrary lines must be drawn.

Parameters:
- SCREEN_WIDTH, 160, visible columns; pixels with x >= this are not plotted.
- SCREEN_HEIGHT, 120, visible rows; pixels with y >= this are not plotted.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- CW, 3, colour width (RGB, 1 bit each).

Ports:
- clk  in  1  rising-edge clock, same clock as the VGA adapter.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- x0  in  XW  start column, unsigned.
- y0  in  YW  start row, unsigned.
- x1  in  XW  end column, unsigned.
- y1  in  YW  end row, unsigned.
- colour_in  in  CW  line colour.
- x  out  XW  pixel column to the adapter.
- y  out  YW  pixel row to the adapter.
- colour  out  CW  pixel colour to the adapter.
- plot  out  1  pixel write strobe to the adapter.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- All outputs are registered.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0; state=IDLE.
- Reset mid-line: IDLE on the next edge, plot=0, no done pulse.
- States and transitions:
  - IDLE: on start=1, latch x0, y0, x1, y1 and colour_in, then go to INIT. While busy=1, start is ignored.
  - INIT (1 cycle): compute the setup values below; cur=(x0,y0); busy=1; plot=0.
  - DRAW: each cycle drive x/y=cur and colour=latched colour; plot=1 only if cur x < SCREEN_WIDTH and cur y < SCREEN_HEIGHT.
    - If cur==(x1,y1), go to DONE.
    - Otherwise compute e2=2*err, then apply both updates using the pre-update err:
      - if e2 >= dy: err+=dy, cur x+=sx;
      - if e2 <= dx: err+=dx, cur y+=sy.
  - DONE (1 cycle): plot=0, busy=0, done=1, then go to IDLE.
- Setup values computed in INIT:
  - dx=|x1-x0| (9b signed, >= 0);
  - dy=-|y1-y0| (9b signed, <= 0);
  - sx=+1 if x0<x1, else -1;
  - sy=+1 if y0<y1, else -1;
  - err=dx+dy.
- Arithmetic widths: err is 10b signed and e2 is 11b signed, with no overflow for any 8b/7b endpoints. Coordinate steps wrap modulo 2^XW / 2^YW, but the termination test guarantees wrap never occurs.
- Latency:
  - start accepted at edge N; first plot at edge N+2.
  - plot cycles = max(|dx|,|dy|)+1, including clipped pixels, which still consume a cycle.
  - done at edge N+2+max(|dx|,|dy|)+1.
- Zero-length line (x0==x1, y0==y1): exactly one plot cycle, then done.
- start and reset together: reset wins.
- Endpoint inputs may change freely after acceptance; only the latched copies are used.

Decomposition:
- Shared package/include draw_defs:
  - SCREEN_WIDTH, SCREEN_HEIGHT;
  - colour constants BLACK=000, BLUE=001, GREEN=010, RED=100, YELLOW=110, WHITE=111;
  - XW/YW/CW;
  - state encodings for IDLE/INIT/DRAW/DONE.
- One sub-module, bresenham_step: purely combinational. Takes err, dx, dy, sx, sy and the current x/y; returns the next err and next x/y. It is instantiated once in the DRAW datapath and unit-testable on its own.

Test Plan:
- Horizontal line (0,0)->(5,0), colour GREEN -> six plot cycles with x=0,1,2,3,4,5 and y=0, colour=010; done one cycle after the last plot; busy low with done.
- Steep line (0,0)->(2,5) -> plot sequence (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), then done.
- Reverse vertical line (3,10)->(3,7) -> y=10,9,8,7 at x=3; exactly 4 plots.
- Zero-length line at (159,119) -> exactly one plot at (159,119); first plot exactly 2 edges after start.
- Clipping, line (158,0)->(162,0) -> 5 DRAW cycles; plot=1 only for x=158 and x=159; done after the 5th cycle.
- Reset asserted during the 3rd pixel of (0,0)->(20,20) -> next edge: plot=0, busy=0, no done pulse. A start pulse applied while busy in a separate run is ignored: the original line completes unchanged.
